// File: rtl/pll_lock_supervisor.sv
// Sequences the Ethernet PLL reset and qualifies its lock: retries on timeout, re-initialises on lock loss.
// All outputs registered; lock_in reaches the FSM through a 2-flop synchronizer. No backpressure.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 64,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       lock_in,
    output logic       pll_reset,
    output logic       ready,
    output logic       rst_out,
    output logic       relock_evt,
    output logic [3:0] retry_cnt,
    output logic       fail
);

    localparam int RW = (PLL_RST_CYCLES > 1) ? $clog2(PLL_RST_CYCLES) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [RW-1:0] RST_LAST  = RW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] STB_DONE  = SW'(LOCK_STABLE_CYCLES);
    localparam logic [SW-1:0] STB_ONE   = SW'(1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        RST_PLL   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAILED    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [SW-1:0] stb_cnt_q, stb_cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          relock_d;
    logic          lock_meta_q, lock_s_q;
    logic          pll_reset_q, ready_q, rst_out_q, relock_q, fail_q;
    logic          timeout;

    assign timeout = (to_cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        stb_cnt_d = stb_cnt_q;
        retry_d   = retry_q;
        relock_d  = 1'b0;
        case (state_q)
            RST_PLL: begin
                to_cnt_d  = '0;
                stb_cnt_d = '0;
                if (rst_cnt_q == RST_LAST) begin
                    rst_cnt_d = '0;
                    state_d   = WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // A one-cycle qualification window completes on the very first locked cycle.
                if (lock_s_q && (STB_DONE == STB_ONE)) begin
                    state_d = RUN;
                end else if (timeout) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAILED;
                    end else begin
                        retry_d   = retry_q + 4'd1;
                        rst_cnt_d = '0;
                        state_d   = RST_PLL;
                    end
                end else if (lock_s_q) begin
                    stb_cnt_d = STB_ONE;
                    state_d   = STABLE;
                end
            end
            STABLE: begin
                to_cnt_d  = to_cnt_q + 1'b1;
                stb_cnt_d = stb_cnt_q + 1'b1;
                // Completion beats timeout; timeout beats a lock drop.
                if (lock_s_q && (stb_cnt_d == STB_DONE)) begin
                    state_d = RUN;
                end else if (timeout) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = FAILED;
                    end else begin
                        retry_d   = retry_q + 4'd1;
                        rst_cnt_d = '0;
                        state_d   = RST_PLL;
                    end
                end else if (!lock_s_q) begin
                    stb_cnt_d = '0;
                    state_d   = WAIT_LOCK;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    rst_cnt_d = '0;
                    relock_d  = 1'b1;
                    state_d   = RST_PLL;
                end
            end
            FAILED: begin
                state_d = FAILED;
            end
            default: begin
                rst_cnt_d = '0;
                state_d   = RST_PLL;
            end
        endcase
        if ((state_d == RUN) && (state_q != RUN)) begin
            retry_d = '0;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= RST_PLL;
            rst_cnt_q   <= '0;
            to_cnt_q    <= '0;
            stb_cnt_q   <= '0;
            retry_q     <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            pll_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            rst_out_q   <= 1'b1;
            relock_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            retry_q     <= retry_d;
            lock_meta_q <= lock_in;
            lock_s_q    <= lock_meta_q;
            pll_reset_q <= (state_d == RST_PLL);
            ready_q     <= (state_d == RUN);
            rst_out_q   <= (state_d != RUN);
            relock_q    <= relock_d;
            fail_q      <= (state_d == FAILED);
        end
    end

    assign pll_reset  = pll_reset_q;
    assign ready      = ready_q;
    assign rst_out    = rst_out_q;
    assign relock_evt = relock_q;
    assign retry_cnt  = retry_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with PLL_RST=4, STABLE=8, TIMEOUT=50, MAX_RETRIES=2.
module tb_pll_lock_supervisor;

    logic       clkin   = 1'b0;
    logic       reset   = 1'b1;
    logic       lock_in = 1'b0;
    logic       pll_reset, ready, rst_out, relock_evt, fail;
    logic [3:0] retry_cnt;

    int tests       = 0;
    int fails       = 0;
    int relock_seen = 0;

    always #5 clkin = ~clkin;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES     (4),
        .LOCK_STABLE_CYCLES (8),
        .LOCK_TIMEOUT_CYCLES(50),
        .MAX_RETRIES        (2)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock_in   (lock_in),
        .pll_reset (pll_reset),
        .ready     (ready),
        .rst_out   (rst_out),
        .relock_evt(relock_evt),
        .retry_cnt (retry_cnt),
        .fail      (fail)
    );

    task automatic tick();
        @(posedge clkin);
        #1;
        if (relock_evt) relock_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench just after the last reset edge with reset already released (t = 0).
    task automatic do_reset();
        reset   = 1'b1;
        lock_in = 1'b0;
        ticks(3);
        reset = 1'b0;
    endtask

    task automatic wait_ready(input int max_n, output int n);
        n = -1;
        for (int i = 1; i <= max_n; i++) begin
            tick();
            if (ready) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] got;
        reset   = 1'b1;
        lock_in = 1'b0;
        ticks(3);
        got = {pll_reset, ready, rst_out, relock_evt, retry_cnt, fail};
        tests++;
        if (got !== 9'b1_0_1_0_0000_0) begin
            fails++;
            $display("FAIL reset_values: got %b want %b", got, 9'b1_0_1_0_0000_0);
        end
    endtask

    task automatic test_clean_start();
        int hi;
        int n;
        do_reset();
        relock_seen = 0;
        hi = pll_reset ? 1 : 0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (pll_reset) hi++;
        end
        tests++;
        if (hi !== 4) begin
            fails++;
            $display("FAIL clean_pll_reset_len: got %0d want 4", hi);
        end
        lock_in = 1'b1;
        wait_ready(30, n);
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL clean_ready_latency: got %0d want 10", n);
        end
        tests++;
        if ({retry_cnt, rst_out, fail} !== 6'b0000_0_0) begin
            fails++;
            $display("FAIL clean_outputs: got retry=%0d rst_out=%b fail=%b want 0 0 0", retry_cnt, rst_out, fail);
        end
        tests++;
        if (relock_seen !== 0) begin
            fails++;
            $display("FAIL clean_no_relock: got %0d pulses want 0", relock_seen);
        end
    endtask

    task automatic test_glitch();
        logic early;
        int   n;
        do_reset();
        ticks(4);
        early   = 1'b0;
        lock_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            early |= ready;
        end
        lock_in = 1'b0;
        tick();
        early |= ready;
        lock_in = 1'b1;
        wait_ready(30, n);
        tests++;
        if (early !== 1'b0) begin
            fails++;
            $display("FAIL glitch_no_early_ready: got %b want 0", early);
        end
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL glitch_ready_latency: got %0d want 10", n);
        end
    endtask

    task automatic test_timeout_retry();
        logic       exp_pr, exp_fail;
        logic [3:0] exp_retry;
        logic [7:0] got, exp;
        do_reset();
        for (int t = 1; t <= 200; t++) begin
            tick();
            exp_pr    = (t <= 3) || (t >= 54 && t <= 57) || (t >= 108 && t <= 111);
            exp_retry = (t < 54) ? 4'd0 : (t < 108) ? 4'd1 : 4'd2;
            exp_fail  = (t >= 162);
            got = {pll_reset, retry_cnt, fail, ready, rst_out};
            exp = {exp_pr, exp_retry, exp_fail, 1'b0, 1'b1};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL timeout_t%0d: got pr/retry/fail/ready/rst=%b want %b", t, got, exp);
            end
        end
    endtask

    task automatic test_fail_reset();
        logic [8:0] got;
        reset = 1'b1;
        tick();
        got = {pll_reset, ready, rst_out, relock_evt, retry_cnt, fail};
        tests++;
        if (got !== 9'b1_0_1_0_0000_0) begin
            fails++;
            $display("FAIL reset_from_fail: got %b want %b", got, 9'b1_0_1_0_0000_0);
        end
        reset = 1'b0;
        ticks(3);
        tests++;
        if ({pll_reset, fail} !== 2'b10) begin
            fails++;
            $display("FAIL restart_t3: got pr/fail=%b want 10", {pll_reset, fail});
        end
        tick();
        tests++;
        if (pll_reset !== 1'b0) begin
            fails++;
            $display("FAIL restart_t4: got pll_reset=%b want 0", pll_reset);
        end
    endtask

    task automatic test_relock();
        int n;
        do_reset();
        ticks(4);
        lock_in = 1'b1;
        wait_ready(30, n);
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL relock_first_ready: got %0d want 10", n);
        end
        ticks(3);
        lock_in     = 1'b0;
        relock_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 2) begin
                tests++;
                if ({ready, relock_evt, pll_reset} !== 3'b100) begin
                    fails++;
                    $display("FAIL relock_i2: got ready/relock/pr=%b want 100", {ready, relock_evt, pll_reset});
                end
            end
            if (i == 3) begin
                tests++;
                if ({ready, rst_out, pll_reset, relock_evt} !== 4'b0111) begin
                    fails++;
                    $display("FAIL relock_i3: got ready/rst/pr/relock=%b want 0111", {ready, rst_out, pll_reset, relock_evt});
                end
            end
            if (i == 6) begin
                tests++;
                if ({pll_reset, relock_evt} !== 2'b10) begin
                    fails++;
                    $display("FAIL relock_i6: got pr/relock=%b want 10", {pll_reset, relock_evt});
                end
            end
            if (i == 7) begin
                tests++;
                if (pll_reset !== 1'b0) begin
                    fails++;
                    $display("FAIL relock_i7: got pll_reset=%b want 0", pll_reset);
                end
            end
        end
        tests++;
        if (relock_seen !== 1) begin
            fails++;
            $display("FAIL relock_pulse_count: got %0d want 1", relock_seen);
        end
        lock_in = 1'b1;
        wait_ready(40, n);
        tests++;
        if (n !== 10) begin
            fails++;
            $display("FAIL relock_requalify: got %0d want 10", n);
        end
        tests++;
        if (retry_cnt !== 4'd0) begin
            fails++;
            $display("FAIL relock_retry: got %0d want 0", retry_cnt);
        end
    endtask

    task automatic test_recovery();
        do_reset();
        ticks(60);
        tests++;
        if ({retry_cnt, pll_reset} !== 5'b0001_0) begin
            fails++;
            $display("FAIL recovery_t60: got retry=%0d pr=%b want 1 0", retry_cnt, pll_reset);
        end
        lock_in = 1'b1;
        ticks(9);
        tests++;
        if ({ready, retry_cnt} !== 5'b0_0001) begin
            fails++;
            $display("FAIL recovery_before_ready: got ready=%b retry=%0d want 0 1", ready, retry_cnt);
        end
        tick();
        tests++;
        if ({ready, retry_cnt} !== 5'b1_0000) begin
            fails++;
            $display("FAIL recovery_at_ready: got ready=%b retry=%0d want 1 0", ready, retry_cnt);
        end
    endtask

    task automatic test_reset_mid_stable();
        logic [8:0] got;
        int         n;
        do_reset();
        ticks(4);
        lock_in = 1'b1;
        ticks(6);
        tests++;
        if ({ready, pll_reset} !== 2'b00) begin
            fails++;
            $display("FAIL mid_stable_pre: got ready/pr=%b want 00", {ready, pll_reset});
        end
        reset = 1'b1;
        tick();
        got = {pll_reset, ready, rst_out, relock_evt, retry_cnt, fail};
        tests++;
        if (got !== 9'b1_0_1_0_0000_0) begin
            fails++;
            $display("FAIL reset_mid_stable: got %b want %b", got, 9'b1_0_1_0_0000_0);
        end
        reset = 1'b0;
        wait_ready(40, n);
        tests++;
        if (n !== 12) begin
            fails++;
            $display("FAIL mid_stable_restart_ready: got %0d want 12", n);
        end
    endtask

    initial begin
        test_reset();
        test_clean_start();
        test_glitch();
        test_timeout_retry();
        test_fail_reset();
        test_relock();
        test_recovery();
        test_reset_mid_stable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
